// File: rtl/hazard_controller_if.sv
// Bundle between the pipeline datapath and the hazard controller: hazard
// sources flow in, PC/latch enables, flushes and status flow back out.
interface hazard_controller_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             dREN_mem;
    logic             dWEN_mem;
    logic             mem_read_ex;
    logic [REG_W-1:0] wsel_ex;
    logic [REG_W-1:0] rsel1_id;
    logic [REG_W-1:0] rsel2_id;
    logic             uses_rs2_id;
    logic             redirect_mem;
    logic             halt_mem;

    logic             pc_en;
    logic             en_ifid;
    logic             en_idex;
    logic             en_exmem;
    logic             en_memwb;
    logic             flush_ifid;
    logic             flush_idex;
    logic             flush_exmem;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    // Pipeline side: drives hazard sources, consumes the control outputs.
    modport master (
        output ihit, dhit, dREN_mem, dWEN_mem, mem_read_ex, wsel_ex,
               rsel1_id, rsel2_id, uses_rs2_id, redirect_mem, halt_mem,
        input  pc_en, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, flush_exmem, halted, stall_cycles
    );

    // Controller side.
    modport slave (
        input  ihit, dhit, dREN_mem, dWEN_mem, mem_read_ex, wsel_ex,
               rsel1_id, rsel2_id, uses_rs2_id, redirect_mem, halt_mem,
        output pc_en, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, flush_exmem, halted, stall_cycles
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage core: resolves D-cache waits,
// HALT, MEM-stage redirects, load-use and I-fetch misses; counts stall cycles.
module hazard_controller #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_controller_if.slave  hz
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DWAIT  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

    logic pc_en, en_ifid, en_idex, en_exmem, en_memwb;
    logic flush_ifid, flush_idex, flush_exmem, halted;
    logic dmem_wait, load_use;

    assign dmem_wait = (hz.dREN_mem || hz.dWEN_mem) && !hz.dhit;

    // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = hz.mem_read_ex && (hz.wsel_ex != '0) &&
                      ((hz.wsel_ex == hz.rsel1_id) ||
                       (hz.uses_rs2_id && (hz.wsel_ex == hz.rsel2_id)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_en       = 1'b0;
        en_ifid     = 1'b0;
        en_idex     = 1'b0;
        en_exmem    = 1'b0;
        en_memwb    = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        halted      = 1'b0;

        if (rst_n) begin
            case (state_reg)
                ST_HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    // RUN and DWAIT share one priority chain; DWAIT merely records
                    // that the previous cycle was a D-cache wait.
                    state_next = ST_RUN;
                    if (dmem_wait) begin
                        state_next = ST_DWAIT;
                    end else if (hz.halt_mem) begin
                        en_memwb   = 1'b1;
                        state_next = ST_HALTED;
                    end else if (hz.redirect_mem) begin
                        pc_en       = 1'b1;
                        en_ifid     = 1'b1;
                        en_idex     = 1'b1;
                        en_exmem    = 1'b1;
                        en_memwb    = 1'b1;
                        flush_ifid  = 1'b1;
                        flush_idex  = 1'b1;
                        flush_exmem = 1'b1;
                    end else if (load_use) begin
                        en_idex    = 1'b1;
                        flush_idex = 1'b1;
                        en_exmem   = 1'b1;
                        en_memwb   = 1'b1;
                    end else if (!hz.ihit) begin
                        en_ifid    = 1'b1;
                        flush_ifid = 1'b1;
                        en_idex    = 1'b1;
                        en_exmem   = 1'b1;
                        en_memwb   = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        en_ifid  = 1'b1;
                        en_idex  = 1'b1;
                        en_exmem = 1'b1;
                        en_memwb = 1'b1;
                    end
                end
            endcase
        end
    end

    // Saturating count of PC-stalled cycles; the halt-entry cycle counts, HALTED does not.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (!pc_en && (state_reg != ST_HALTED) && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.en_ifid      = en_ifid;
    assign hz.en_idex      = en_idex;
    assign hz.en_exmem     = en_exmem;
    assign hz.en_memwb     = en_memwb;
    assign hz.flush_ifid   = flush_ifid;
    assign hz.flush_idex   = flush_idex;
    assign hz.flush_exmem  = flush_exmem;
    assign hz.halted       = halted;
    assign hz.stall_cycles = stall_cnt_reg;
endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus randomized
// traffic, checked against a rule-table reference model kept here.
module tb_hazard_controller;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Output vector order: {pc_en, en_ifid, en_idex, en_exmem, en_memwb,
    //                       flush_ifid, flush_idex, flush_exmem, halted}
    localparam logic [8:0] O_ZERO   = 9'b000000000;
    localparam logic [8:0] O_HALTED = 9'b000000001;
    localparam logic [8:0] O_HALT   = 9'b000010000;
    localparam logic [8:0] O_REDIR  = 9'b111111110;
    localparam logic [8:0] O_LDUSE  = 9'b001110100;
    localparam logic [8:0] O_IMISS  = 9'b011111000;
    localparam logic [8:0] O_RUN    = 9'b111110000;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;
    int   m_cnt;
    bit   m_halted;

    hazard_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif ();

    hazard_controller #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [8:0] dut_out = {hif.pc_en, hif.en_ifid, hif.en_idex, hif.en_exmem, hif.en_memwb,
                          hif.flush_ifid, hif.flush_idex, hif.flush_exmem, hif.halted};

    // Reference model: the priority rules read straight off the behaviour list.
    function automatic logic [8:0] exp_out();
        bit hazard_lu;
        if (!rst_n)   return O_ZERO;
        if (m_halted) return O_HALTED;
        if ((hif.dREN_mem || hif.dWEN_mem) && !hif.dhit) return O_ZERO;
        if (hif.halt_mem)     return O_HALT;
        if (hif.redirect_mem) return O_REDIR;
        hazard_lu = hif.mem_read_ex && (hif.wsel_ex != 0) &&
                    (hif.wsel_ex == hif.rsel1_id || (hif.uses_rs2_id && hif.wsel_ex == hif.rsel2_id));
        if (hazard_lu) return O_LDUSE;
        if (!hif.ihit) return O_IMISS;
        return O_RUN;
    endfunction

    task automatic idle_inputs();
        hif.ihit = 1'b1; hif.dhit = 1'b0; hif.dREN_mem = 1'b0; hif.dWEN_mem = 1'b0;
        hif.mem_read_ex = 1'b0; hif.wsel_ex = '0; hif.rsel1_id = '0; hif.rsel2_id = '0;
        hif.uses_rs2_id = 1'b0; hif.redirect_mem = 1'b0; hif.halt_mem = 1'b0;
    endtask

    // Advance one clock edge, updating the model from the pre-edge outputs.
    task automatic tick(input string name);
        logic [8:0] e;
        e = exp_out();
        $display("[%0t] %s out=%b cnt=%0d", $time, name, dut_out, hif.stall_cycles);
        if (rst_n) begin
            if (!m_halted && !e[8] && m_cnt < CNT_MAX) m_cnt++;
            if (e == O_HALT) m_halted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        m_cnt = 0;
        m_halted = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        m_cnt = 0; m_halted = 1'b0;
        #3;
        checks++;
        if (dut_out !== O_ZERO) begin fails++; $display("FAIL reset_out got=%b want=%b", dut_out, O_ZERO); end
        checks++;
        if (hif.stall_cycles !== 4'd0) begin fails++; $display("FAIL reset_cnt got=%0d want=0", hif.stall_cycles); end
        apply_reset();
        checks++;
        if (dut_out !== O_RUN) begin fails++; $display("FAIL reset_release got=%b want=%b", dut_out, O_RUN); end
    endtask

    task automatic test_load_use();
        apply_reset();
        for (int pass = 0; pass < 2; pass++) begin
            hif.mem_read_ex = 1'b1; hif.wsel_ex = 5'd5; hif.rsel1_id = 5'd7;
            hif.rsel2_id = 5'd5; hif.uses_rs2_id = (pass == 0); hif.ihit = 1'b1;
            #1;
            checks++;
            if (dut_out !== exp_out()) begin fails++; $display("FAIL load_use pass%0d got=%b want=%b", pass, dut_out, exp_out()); end
            tick("load_use");
            // Load has moved on to MEM: EX no longer holds it.
            hif.mem_read_ex = 1'b0;
            #1;
            checks++;
            if (dut_out !== O_RUN) begin fails++; $display("FAIL load_use_clear pass%0d got=%b want=%b", pass, dut_out, O_RUN); end
            checks++;
            if (hif.stall_cycles !== m_cnt[CNT_W-1:0]) begin fails++; $display("FAIL load_use_cnt pass%0d got=%0d want=%0d", pass, hif.stall_cycles, m_cnt); end
        end
        // Register 0 never triggers load-use.
        hif.mem_read_ex = 1'b1; hif.wsel_ex = '0; hif.rsel1_id = '0;
        #1;
        checks++;
        if (dut_out !== O_RUN) begin fails++; $display("FAIL load_use_r0 got=%b want=%b", dut_out, O_RUN); end
        tick("load_use_r0");
        idle_inputs();
    endtask

    task automatic test_dmiss();
        apply_reset();
        hif.dREN_mem = 1'b1; hif.dhit = 1'b0;
        for (int c = 0; c < 4; c++) begin
            hif.dhit = (c == 3);
            #1;
            checks++;
            if (dut_out !== exp_out()) begin fails++; $display("FAIL dmiss cyc%0d got=%b want=%b", c, dut_out, exp_out()); end
            tick("dmiss");
        end
        checks++;
        if (hif.stall_cycles !== 4'd3) begin fails++; $display("FAIL dmiss_cnt got=%0d want=3", hif.stall_cycles); end
        idle_inputs();
    endtask

    task automatic test_redirect();
        apply_reset();
        hif.redirect_mem = 1'b1; hif.mem_read_ex = 1'b1; hif.wsel_ex = 5'd3;
        hif.rsel1_id = 5'd3; hif.ihit = 1'b0;
        #1;
        checks++;
        if (dut_out !== O_REDIR) begin fails++; $display("FAIL redirect got=%b want=%b", dut_out, O_REDIR); end
        tick("redirect");
        checks++;
        if (hif.stall_cycles !== 4'd0) begin fails++; $display("FAIL redirect_cnt got=%0d want=0", hif.stall_cycles); end
        idle_inputs();
    endtask

    task automatic test_halt();
        apply_reset();
        hif.ihit = 1'b0;
        tick("pre_halt");
        hif.ihit = 1'b1; hif.halt_mem = 1'b1;
        #1;
        checks++;
        if (dut_out !== O_HALT) begin fails++; $display("FAIL halt_entry got=%b want=%b", dut_out, O_HALT); end
        tick("halt");
        hif.halt_mem = 1'b0;
        for (int c = 0; c < 10; c++) begin
            hif.ihit = 1'($urandom_range(0, 1));
            hif.redirect_mem = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (dut_out !== O_HALTED) begin fails++; $display("FAIL halted_out cyc%0d got=%b want=%b", c, dut_out, O_HALTED); end
            tick("halted");
        end
        checks++;
        if (hif.stall_cycles !== 4'd2) begin fails++; $display("FAIL halt_cnt got=%0d want=2", hif.stall_cycles); end
        apply_reset();
        checks++;
        if (hif.halted !== 1'b0) begin fails++; $display("FAIL halt_reset got=%b want=0", hif.halted); end
    endtask

    task automatic test_saturation();
        apply_reset();
        hif.ihit = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++;
            if (hif.flush_ifid !== 1'b1 || dut_out !== O_IMISS) begin
                fails++; $display("FAIL sat_imiss cyc%0d got=%b want=%b", c, dut_out, O_IMISS);
            end
            tick("imiss");
        end
        checks++;
        if (hif.stall_cycles !== 4'd15) begin fails++; $display("FAIL sat_cnt got=%0d want=15", hif.stall_cycles); end
        idle_inputs();
    endtask

    task automatic test_reset_dwait();
        apply_reset();
        hif.dREN_mem = 1'b1; hif.dhit = 1'b0;
        tick("dwait1");
        #2;
        rst_n = 1'b0;
        m_cnt = 0; m_halted = 1'b0;
        #1;
        checks++;
        if (dut_out !== O_ZERO || hif.stall_cycles !== 4'd0) begin
            fails++; $display("FAIL rst_dwait got=%b cnt=%0d want=%b cnt=0", dut_out, hif.stall_cycles, O_ZERO);
        end
        @(posedge clk); #1;
        hif.dREN_mem = 1'b0; hif.ihit = 1'b1;
        rst_n = 1'b1;
        #1;
        tick("rst_release");
        checks++;
        if (dut_out !== O_RUN || hif.stall_cycles !== 4'd0) begin
            fails++; $display("FAIL rst_dwait_release got=%b cnt=%0d want=%b cnt=0", dut_out, hif.stall_cycles, O_RUN);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            if (m_halted) apply_reset();
            hif.ihit         = ($urandom_range(0, 3) != 0);
            hif.dREN_mem     = ($urandom_range(0, 4) == 0);
            hif.dWEN_mem     = ($urandom_range(0, 6) == 0);
            hif.dhit         = 1'($urandom_range(0, 1));
            hif.mem_read_ex  = 1'($urandom_range(0, 1));
            hif.wsel_ex      = 5'($urandom_range(0, 3));
            hif.rsel1_id     = 5'($urandom_range(0, 3));
            hif.rsel2_id     = 5'($urandom_range(0, 3));
            hif.uses_rs2_id  = 1'($urandom_range(0, 1));
            hif.redirect_mem = ($urandom_range(0, 7) == 0);
            hif.halt_mem     = ($urandom_range(0, 39) == 0);
            #1;
            checks++;
            if (dut_out !== exp_out()) begin fails++; $display("FAIL rand_out cyc%0d got=%b want=%b", c, dut_out, exp_out()); end
            checks++;
            if (hif.stall_cycles !== m_cnt[CNT_W-1:0]) begin fails++; $display("FAIL rand_cnt cyc%0d got=%0d want=%0d", c, hif.stall_cycles, m_cnt); end
            tick("rand");
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        fails = 0;
        test_reset();
        test_load_use();
        test_dmiss();
        test_redirect();
        test_halt();
        test_saturation();
        test_reset_dwait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
